// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface inst_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// MIPS fetch stage: next-PC selection, req/ack fetch from instruction memory,
// one-entry stall buffer and redirect flush in front of the IF/ID register.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_INST = 32'h0000_0000,
    parameter logic [31:0] PC_STEP    = 32'd4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc_in,
    output logic [31:0]        pc_next,
    output logic               pc_ena,
    input  logic               redirect,
    input  logic [31:0]        redirect_target,
    input  logic               stall,
    inst_fetch_unit_if.master  imem,
    output logic               id_valid,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_inst
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] req_addr;
    logic [31:0] req_addr_nxt;
    logic [31:0] buf_pc;
    logic [31:0] buf_pc_nxt;
    logic [31:0] buf_inst;
    logic [31:0] buf_inst_nxt;

    logic        id_valid_nxt;
    logic [31:0] id_pc_nxt;
    logic [31:0] id_inst_nxt;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

    // PC selection and memory request; a response only advances the PC when it is wanted.
    always_comb begin
        pc_next        = redirect ? redirect_target : seq_pc(pc_in);
        pc_ena         = redirect | ((state == S_WAIT) & imem.imem_ack);
        imem.imem_req  = (state == S_WAIT) || (state == S_DROP);
        imem.imem_addr = (state == S_DROP) ? req_addr : pc_in;
    end

    always_comb begin
        state_nxt    = state;
        req_addr_nxt = req_addr;
        buf_pc_nxt   = buf_pc;
        buf_inst_nxt = buf_inst;
        id_valid_nxt = id_valid;
        id_pc_nxt    = id_pc;
        id_inst_nxt  = id_inst;

        case (state)
            S_IDLE: begin
                state_nxt = S_WAIT;
            end

            S_WAIT: begin
                if (redirect) begin
                    id_valid_nxt = 1'b0;
                    id_inst_nxt  = RESET_INST;
                    if (!imem.imem_ack) begin
                        // Keep presenting the old address until the abandoned request completes.
                        req_addr_nxt = pc_in;
                        state_nxt    = S_DROP;
                    end
                end else if (imem.imem_ack) begin
                    if (stall) begin
                        buf_pc_nxt   = pc_in;
                        buf_inst_nxt = imem.imem_rdata;
                        state_nxt    = S_HOLD;
                    end else begin
                        id_valid_nxt = 1'b1;
                        id_pc_nxt    = pc_in;
                        id_inst_nxt  = imem.imem_rdata;
                    end
                end else if (!stall) begin
                    id_valid_nxt = 1'b0;
                    id_inst_nxt  = RESET_INST;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    id_valid_nxt = 1'b0;
                    id_inst_nxt  = RESET_INST;
                    state_nxt    = S_WAIT;
                end else if (!stall) begin
                    id_valid_nxt = 1'b1;
                    id_pc_nxt    = buf_pc;
                    id_inst_nxt  = buf_inst;
                    state_nxt    = S_WAIT;
                end
            end

            S_DROP: begin
                if (redirect) begin
                    id_valid_nxt = 1'b0;
                    id_inst_nxt  = RESET_INST;
                end
                if (imem.imem_ack) begin
                    state_nxt = S_WAIT;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            req_addr <= 32'h0;
            buf_pc   <= 32'h0;
            buf_inst <= 32'h0;
            id_valid <= 1'b0;
            id_pc    <= 32'h0;
            id_inst  <= RESET_INST;
        end else begin
            state    <= state_nxt;
            req_addr <= req_addr_nxt;
            buf_pc   <= buf_pc_nxt;
            buf_inst <= buf_inst_nxt;
            id_valid <= id_valid_nxt;
            id_pc    <= id_pc_nxt;
            id_inst  <= id_inst_nxt;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inst_fetch_unit;

    localparam logic [31:0] RST_INST = 32'h0000_0000;
    localparam logic [31:0] PC_START = 32'h0040_0000;
    localparam logic [31:0] SALT     = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        pc_ena;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    inst_fetch_unit_if imem_bus();

    inst_fetch_unit #(
        .RESET_INST (RST_INST),
        .PC_STEP    (32'd4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_in           (pc_in),
        .pc_next         (pc_next),
        .pc_ena          (pc_ena),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .stall           (stall),
        .imem            (imem_bus),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_inst         (id_inst)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a started flag, an optional discarded in-flight request,
    // an optional parked instruction, the IF/ID contents and the PC register.
    bit          m_known   = 1'b0;
    bit          m_active  = 1'b0;
    bit          m_discard = 1'b0;
    bit          m_has_buf = 1'b0;
    bit          m_v       = 1'b0;
    logic [31:0] m_drop_addr = '0;
    logic [31:0] m_buf_pc    = '0;
    logic [31:0] m_buf_inst  = '0;
    logic [31:0] m_pc        = '0;
    logic [31:0] m_inst      = '0;
    logic [31:0] m_pcreg     = PC_START;

    logic [31:0] cap_pc_next;
    logic [31:0] cap_addr;
    logic        cap_pc_ena;
    logic        cap_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit a, input bit s, input bit rd,
                         input logic [31:0] tgt, input logic [31:0] rdat);
        bit          e_req;
        bit          e_ena;
        logic [31:0] e_addr;
        logic [31:0] e_next;
        e_req  = 1'b0;
        e_ena  = 1'b0;
        e_addr = '0;
        e_next = '0;
        rst                 = r;
        imem_bus.imem_ack   = a;
        imem_bus.imem_rdata = rdat;
        stall               = s;
        redirect            = rd;
        redirect_target     = tgt;
        pc_in               = m_pcreg;
        @(negedge clk);
        cap_pc_next = pc_next;
        cap_pc_ena  = pc_ena;
        cap_req     = imem_bus.imem_req;
        cap_addr    = imem_bus.imem_addr;
        if (m_known) begin
            e_req  = m_active && !m_has_buf;
            e_addr = m_discard ? m_drop_addr : pc_in;
            e_ena  = rd || (e_req && a && !m_discard);
            e_next = rd ? tgt : pc_in + 32'd4;
            chk("pc_next", pc_next, e_next);
            chk("pc_ena", {31'b0, pc_ena}, {31'b0, e_ena});
            chk("imem_req", {31'b0, imem_bus.imem_req}, {31'b0, e_req});
            if (e_req) chk("imem_addr", imem_bus.imem_addr, e_addr);
            chk("id_valid", {31'b0, id_valid}, {31'b0, m_v});
            if (m_v) chk("id_pc", id_pc, m_pc);
            chk("id_inst", id_inst, m_v ? m_inst : RST_INST);
        end
        if (!r) begin
            m_known   = 1'b1;
            m_active  = 1'b0;
            m_discard = 1'b0;
            m_has_buf = 1'b0;
            m_v       = 1'b0;
            m_pc      = '0;
            m_inst    = RST_INST;
            m_pcreg   = PC_START;
        end else if (m_known) begin
            if (e_ena) m_pcreg = e_next;
            if (!m_active) begin
                m_active = 1'b1;
            end else if (rd) begin
                m_v       = 1'b0;
                m_inst    = RST_INST;
                m_has_buf = 1'b0;
                if (e_req && !a) begin
                    if (!m_discard) m_drop_addr = pc_in;
                    m_discard = 1'b1;
                end else begin
                    m_discard = 1'b0;
                end
            end else if (m_discard) begin
                if (a) m_discard = 1'b0;
            end else if (m_has_buf) begin
                if (!s) begin
                    m_v       = 1'b1;
                    m_pc      = m_buf_pc;
                    m_inst    = m_buf_inst;
                    m_has_buf = 1'b0;
                end
            end else if (a) begin
                if (s) begin
                    m_has_buf  = 1'b1;
                    m_buf_pc   = pc_in;
                    m_buf_inst = rdat;
                end else begin
                    m_v    = 1'b1;
                    m_pc   = pc_in;
                    m_inst = rdat;
                end
            end else if (!s) begin
                m_v    = 1'b0;
                m_inst = RST_INST;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic zw(input bit s);
        cycle(1'b1, 1'b1, s, 1'b0, 32'h0, m_pcreg ^ SALT);
    endtask

    initial begin
        // Reset
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst id_pc", id_pc, 32'h0);
        chk("rst id_inst", id_inst, 32'h0);

        // Zero-wait memory
        zw(1'b0);
        chk("idle pc_ena", {31'b0, cap_pc_ena}, 32'd0);
        chk("idle req", {31'b0, cap_req}, 32'd0);
        chk("zw1 id_valid", {31'b0, id_valid}, 32'd0);
        zw(1'b0);
        chk("zw2 pc_ena", {31'b0, cap_pc_ena}, 32'd1);
        chk("zw2 addr", cap_addr, 32'h0040_0000);
        chk("zw2 id_pc", id_pc, 32'h0040_0000);
        chk("zw2 id_inst", id_inst, 32'hA5E5_0000);
        zw(1'b0);
        chk("zw3 id_pc", id_pc, 32'h0040_0004);
        zw(1'b0);
        chk("zw4 id_pc", id_pc, 32'h0040_0008);

        // Ack delayed three cycles
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
            chk("dly req", {31'b0, cap_req}, 32'd1);
            chk("dly addr", cap_addr, 32'h0040_000C);
            chk("dly pc_ena", {31'b0, cap_pc_ena}, 32'd0);
            chk("dly id_valid", {31'b0, id_valid}, 32'd0);
        end
        zw(1'b0);
        chk("dly ack pc_ena", {31'b0, cap_pc_ena}, 32'd1);
        chk("dly id_pc", id_pc, 32'h0040_000C);

        // Stall while an ack arrives
        zw(1'b1);
        chk("stl id_pc", id_pc, 32'h0040_000C);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h1111_1111);
            chk("hold req", {31'b0, cap_req}, 32'd0);
            chk("hold id_pc", id_pc, 32'h0040_000C);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("unstall id_valid", {31'b0, id_valid}, 32'd1);
        chk("unstall id_pc", id_pc, 32'h0040_0010);
        chk("unstall id_inst", id_inst, 32'hA5E5_0010);

        // Redirect with a request outstanding
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 32'h0);
        chk("redir pc_ena", {31'b0, cap_pc_ena}, 32'd1);
        chk("redir pc_next", cap_pc_next, 32'h0040_0100);
        chk("redir id_valid", {31'b0, id_valid}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
        chk("drop addr", cap_addr, 32'h0040_0014);
        chk("drop pc_ena", {31'b0, cap_pc_ena}, 32'd0);
        chk("drop id_valid", {31'b0, id_valid}, 32'd0);
        zw(1'b0);
        chk("retgt addr", cap_addr, 32'h0040_0100);
        chk("retgt id_pc", id_pc, 32'h0040_0100);

        // Redirect + stall + ack together
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0200, 32'hDEAD_BEEF);
        chk("rsa pc_next", cap_pc_next, 32'h0040_0200);
        chk("rsa id_valid", {31'b0, id_valid}, 32'd0);
        chk("rsa id_inst", id_inst, 32'h0);
        zw(1'b0);
        chk("rsa2 id_pc", id_pc, 32'h0040_0200);
        chk("rsa2 id_inst", id_inst, 32'hA5E5_0200);

        // PC wraparound
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
        zw(1'b0);
        chk("wrap pc_next", cap_pc_next, 32'h0);
        chk("wrap id_pc", id_pc, 32'hFFFF_FFFC);

        // Reset during an outstanding request, then a stray ack
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0300, 32'h0);
        chk("mrst id_valid", {31'b0, id_valid}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hBAD0_BAD0);
        chk("mrst req", {31'b0, cap_req}, 32'd0);
        chk("mrst pc_ena", {31'b0, cap_pc_ena}, 32'd0);
        chk("mrst id_inst", id_inst, 32'h0);
        zw(1'b0);
        chk("mrst2 id_pc", id_pc, PC_START);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 199) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) == 0),
                  $urandom & 32'hFFFF_FFFC,
                  $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
